chip_test_sequencer: RTL
========================

# chip_test_sequencer

Front-panel control stage wrapped around a single chip tester (for example the 74151 mux tester). It debounces the operator's start button and issues a one-cycle `Run` pulse to the tester. It then waits for the tester's `Done`, with a timeout, and captures `RSLT`. It drives `DISP_RSLT` and the pass/fail/timeout indicators, and keeps saturating pass and fail tallies for the board display.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change.
- `TIMEOUT_CYCLES`, default 1000000: maximum cycles from `Run` to `Done` before a test is declared timed out.
- `CNT_W`, default 8: width of the pass and fail tallies.

Ports:
- `Clk` in 1: system clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Start_btn` in 1: raw, asynchronous pushbutton, active-high.
- `Clear_cnt` in 1: synchronous clear of both tallies.
- `Done` in 1: from the tester; test complete, level.
- `RSLT` in 1: from the tester; 1 = pass, valid while `Done` = 1.
- `Run` out 1: to the tester; one-cycle start pulse.
- `DISP_RSLT` out 1: to the tester and display; the latched result is being shown.
- `Busy` out 1: a test is in progress.
- `Pass_LED` out 1, `Fail_LED` out 1, `Timeout_LED` out 1: latched outcome of the last test.
- `Pass_Count` out `CNT_W`: number of passed tests.
- `Fail_Count` out `CNT_W`: number of failed plus timed-out tests.

## Operation
- **Button path:** 2-flop synchronizer, then debounce, then rising-edge detect. The edge yields a one-cycle `start_req`.
- **IDLE:** all indicators hold their last value. On `start_req`, clear the three LEDs, deassert `DISP_RSLT` and go to ARM.
- **ARM:** exactly one cycle. `Run` = 1, timeout counter loads 0, `seen_low` flag is cleared. Next state is WAIT.
- **WAIT:** `Busy` = 1 and the timeout counter increments each cycle.
  - `seen_low` sets on the first cycle `Done` = 0. This is the stale-done guard: a `Done` left high from the previous test is ignored.
  - `Done` = 1 with `seen_low` set: go to CAPTURE.
  - Otherwise, counter reaching `TIMEOUT_CYCLES`-1: go to TOUT.
- **CAPTURE:** one cycle. Latch `RSLT` into `Pass_LED`/`Fail_LED`, increment the matching tally, go to SHOW.
- **TOUT:** one cycle. `Timeout_LED` = 1, `Fail_Count` increments, go to SHOW.
- **SHOW:** `DISP_RSLT` = 1 and held. Return to IDLE next cycle; `DISP_RSLT` stays 1 until the next ARM.
- `start_req` outside IDLE is dropped; it is not queued.
- Tallies saturate at all-ones.
- `Clear_cnt` zeroes both tallies and has priority over a same-cycle increment.
- Exactly one of the three LEDs is 1 after any completed test.

## Timing
- Reset values: `Run`, `DISP_RSLT`, `Busy` and all LEDs = 0; tallies = 0; state IDLE; synchronizer, debounce and timeout counters = 0. Reset mid-test aborts immediately with no tally change.
- Latency from the raw button rising (and held stable) to `Run` = 1 is `DEBOUNCE_CYCLES`+4 cycles: 2 synchronizer, `DEBOUNCE_CYCLES` stability, 1 edge, 1 FSM.
- `Run` is high for exactly 1 cycle per accepted press.
- `Busy` is high from the cycle after `Run` through the CAPTURE or TOUT cycle.
- A qualifying `Done` sampled at edge N causes the LEDs and tally to update at edge N+1 and `DISP_RSLT` to rise at edge N+2.
- Timeout: with `Done` never qualifying, TOUT is entered `TIMEOUT_CYCLES` cycles after ARM.
- `Done` qualifying on the same cycle the counter hits its limit counts as a completion, not a timeout.

## Structure
- Shared package `chip_test_pkg` holds:
  - the `seq_state_t` enum: IDLE, ARM, WAIT, CAPTURE, TOUT, SHOW;
  - the `test_outcome_t` enum: PASS, FAIL, TIMEOUT;
  - default `DEBOUNCE_CYCLES` and `TIMEOUT_CYCLES` constants, for reuse by the other chip testers.
- One sub-module, `button_debounce`: synchronizer, stability counter and rising-edge pulse, parameterized by `DEBOUNCE_CYCLES`.

## Test plan
- **Debounce and pulse:** reset with `DEBOUNCE_CYCLES`=4; raise `Start_btn` and hold -> `Run` high for exactly one cycle, 8 cycles after the rise.
- **Pass:** press, tester drives `Done` low then high with `RSLT`=1 after 20 cycles -> `Pass_LED`=1, `Pass_Count`=1, `DISP_RSLT`=1 two edges after `Done`.
- **Stale done / bounce:**
  - `Done` held high from the previous test, then low 5 cycles, then high with `RSLT`=0 -> no capture before the low phase, then `Fail_LED`=1, `Fail_Count`=1.
  - Bounce `Start_btn` shorter than 4 cycles -> no `Run`.
- **Timeout:** `TIMEOUT_CYCLES`=50, `Done` stuck low -> `Timeout_LED`=1 exactly 50 cycles after ARM, `Fail_Count`+1.
- **Saturation and clear:**
  - `CNT_W`=2, four passes -> `Pass_Count`=3.
  - `Clear_cnt` asserted in the CAPTURE cycle -> `Pass_Count`=0.
- **Reset mid-test and re-press:**
  - Deassert-then-assert `Reset` low during WAIT -> all outputs 0 asynchronously, tallies 0.
  - Press during WAIT -> ignored; a single `Run` only.

Source files
------------

// File: rtl/chip_test_pkg.sv
// Shared types and defaults for the chip-tester front-panel sequencers.
package chip_test_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, CAPTURE, TOUT, SHOW} seq_state_t;
  typedef enum logic [1:0] {PASS, FAIL, TIMEOUT} test_outcome_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1000000;

  typedef struct packed {
    logic pass;
    logic fail;
    logic tout;
  } led_set_t;

  // One-hot indicator pattern for a completed test.
  function automatic led_set_t outcome_leds(input test_outcome_t o);
    led_set_t l;
    l.pass = (o == PASS);
    l.fail = (o == FAIL);
    l.tout = (o == TIMEOUT);
    return l;
  endfunction

endpackage

// File: rtl/chip_test_sequencer_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and a
// registered one-cycle pulse on each accepted rising level.
module button_debounce
  import chip_test_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // Accept the new level only after DEBOUNCE_CYCLES consecutive differing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chip_test_sequencer.sv
// Front-panel sequencer for a single chip tester: debounced start, run pulse,
// done/timeout wait, result capture, indicators and saturating tallies.
module chip_test_sequencer
  import chip_test_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start_btn,
  input  logic             Clear_cnt,
  input  logic             Done,
  input  logic             RSLT,
  output logic             Run,
  output logic             DISP_RSLT,
  output logic             Busy,
  output logic             Pass_LED,
  output logic             Fail_LED,
  output logic             Timeout_LED,
  output logic [CNT_W-1:0] Pass_Count,
  output logic [CNT_W-1:0] Fail_Count
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Compared before the increment so TOUT begins TIMEOUT_CYCLES cycles after ARM.
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 2);

  seq_state_t    state;
  seq_state_t    state_nxt;
  test_outcome_t outcome;
  logic          start_req;
  logic          clear_ind;
  logic          latch_en;
  logic          seen_low;
  logic [TW-1:0] tcnt;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (Clk),
    .rst_n(Reset),
    .btn  (Start_btn),
    .pulse(start_req)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_ind = 1'b0;
    latch_en  = 1'b0;
    outcome   = PASS;
    Run       = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req) begin
          clear_ind = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        Run       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        Busy = 1'b1;
        if (Done && seen_low)         state_nxt = CAPTURE;
        else if (tcnt == TCNT_LAST)   state_nxt = TOUT;
      end
      CAPTURE: begin
        Busy      = 1'b1;
        latch_en  = 1'b1;
        outcome   = RSLT ? PASS : FAIL;
        state_nxt = SHOW;
      end
      TOUT: begin
        Busy      = 1'b1;
        latch_en  = 1'b1;
        outcome   = TIMEOUT;
        state_nxt = SHOW;
      end
      SHOW:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      tcnt        <= '0;
      seen_low    <= 1'b0;
      Pass_LED    <= 1'b0;
      Fail_LED    <= 1'b0;
      Timeout_LED <= 1'b0;
      DISP_RSLT   <= 1'b0;
      Pass_Count  <= '0;
      Fail_Count  <= '0;
    end else begin
      if (state == ARM) begin
        tcnt     <= '0;
        seen_low <= 1'b0;
      end else if (state == WAIT) begin
        tcnt <= tcnt + TW'(1);
        // A Done still high from the previous test must drop before it counts.
        if (!Done) seen_low <= 1'b1;
      end

      if (clear_ind) begin
        {Pass_LED, Fail_LED, Timeout_LED} <= '0;
        DISP_RSLT                         <= 1'b0;
      end else if (latch_en) begin
        {Pass_LED, Fail_LED, Timeout_LED} <= outcome_leds(outcome);
      end else if (state == SHOW) begin
        DISP_RSLT <= 1'b1;
      end

      if (Clear_cnt) begin
        Pass_Count <= '0;
        Fail_Count <= '0;
      end else if (latch_en) begin
        if (outcome == PASS) begin
          if (Pass_Count != '1) Pass_Count <= Pass_Count + CNT_W'(1);
        end else begin
          if (Fail_Count != '1) Fail_Count <= Fail_Count + CNT_W'(1);
        end
      end
    end
  end

endmodule
